// File: rtl/vc_input_port_if.sv
// Flit link of one router input port: upstream flits in, on/off credits back,
// and the registered flit leaving toward the crossbar.
interface vc_input_port_if #(
   parameter int VC_NUM  = 2,
   parameter int VC_SIZE = $clog2(VC_NUM),
   parameter int DATA_W  = 20
);
   logic                in_valid;
   logic [1:0]          in_label;
   logic [VC_SIZE-1:0]  in_vc;
   logic [DATA_W-1:0]   in_data;
   logic [VC_NUM-1:0]   on_off;
   logic                out_valid;
   logic [1:0]          out_label;
   logic [VC_SIZE-1:0]  out_vc;
   logic [DATA_W-1:0]   out_data;

   modport master (
      output in_valid, in_label, in_vc, in_data,
      input  on_off, out_valid, out_label, out_vc, out_data
   );

   modport slave (
      input  in_valid, in_label, in_vc, in_data,
      output on_off, out_valid, out_label, out_vc, out_data
   );
endinterface

// File: rtl/vc_input_port.sv
// Router input port: per-VC flit FIFOs, per-VC packet FSM (IDLE/VA/ACTIVE),
// hysteretic on/off flow control and downstream VC rewrite on departure.
module vc_input_port #(
   parameter int VC_NUM        = 2,
   parameter int VC_SIZE       = $clog2(VC_NUM),
   parameter int DATA_W        = 20,
   parameter int BUFFER_DEPTH  = 8,
   parameter int OFF_THRESHOLD = BUFFER_DEPTH - 2,
   parameter int ON_THRESHOLD  = BUFFER_DEPTH / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   vc_input_port_if.slave        link,
   output logic [VC_NUM-1:0]     vc_allocatable,
   output logic [VC_NUM-1:0]     va_req,
   output logic [VC_NUM*3-1:0]   va_x_dest,
   output logic [VC_NUM*3-1:0]   va_y_dest,
   input  logic [VC_NUM-1:0]     va_grant,
   input  logic [VC_SIZE-1:0]    va_vc,
   input  logic [VC_NUM-1:0]     ds_on,
   output logic [VC_NUM-1:0]     sa_req,
   input  logic [VC_NUM-1:0]     sa_grant,
   output logic [VC_NUM-1:0]     err_overflow,
   output logic [VC_NUM-1:0]     err_protocol
);
   localparam int ADDR_W = $clog2(BUFFER_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int FLIT_W = DATA_W + 2;
   localparam logic [PTR_W-1:0] OFF_LVL = PTR_W'(OFF_THRESHOLD);
   localparam logic [PTR_W-1:0] ON_LVL  = PTR_W'(ON_THRESHOLD);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] VA     = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   localparam logic [1:0] LBL_HEAD     = 2'd0;
   localparam logic [1:0] LBL_TAIL     = 2'd2;
   localparam logic [1:0] LBL_HEADTAIL = 2'd3;

   logic [FLIT_W-1:0]  mem [VC_NUM][BUFFER_DEPTH];
   logic [PTR_W-1:0]   wr_ptr [VC_NUM];
   logic [PTR_W-1:0]   rd_ptr [VC_NUM];
   logic [PTR_W-1:0]   occ_next [VC_NUM];
   logic [1:0]         state [VC_NUM];
   logic [VC_SIZE-1:0] ds_vc [VC_NUM];
   logic [FLIT_W-1:0]  front [VC_NUM];

   logic [VC_NUM-1:0]  empty, full, front_head, front_tail, discard;
   logic [VC_NUM-1:0]  sa_hits, served, pop, push, overflow;
   logic [FLIT_W-1:0]  sel_flit;
   logic [VC_SIZE-1:0] sel_vc;

   // Front-of-queue decode; a non-head flit at the front of an idle VC is junk
   always_comb begin
      empty          = '0;
      full           = '0;
      front_head     = '0;
      front_tail     = '0;
      discard        = '0;
      va_req         = '0;
      sa_req         = '0;
      vc_allocatable = '0;
      va_x_dest      = '0;
      va_y_dest      = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         front[v]      = mem[v][rd_ptr[v][ADDR_W-1:0]];
         empty[v]      = (wr_ptr[v] == rd_ptr[v]);
         full[v]       = (wr_ptr[v][ADDR_W] != rd_ptr[v][ADDR_W]) &&
                         (wr_ptr[v][ADDR_W-1:0] == rd_ptr[v][ADDR_W-1:0]);
         front_head[v] = !empty[v] && ((front[v][FLIT_W-1 -: 2] == LBL_HEAD) ||
                                       (front[v][FLIT_W-1 -: 2] == LBL_HEADTAIL));
         front_tail[v] = (front[v][FLIT_W-1 -: 2] == LBL_TAIL) ||
                         (front[v][FLIT_W-1 -: 2] == LBL_HEADTAIL);
         discard[v]    = (state[v] == IDLE) && !empty[v] && !front_head[v];
         va_req[v]     = (state[v] == VA) || ((state[v] == IDLE) && front_head[v]);
         sa_req[v]     = (state[v] == ACTIVE) && !empty[v] && ds_on[ds_vc[v]];
         vc_allocatable[v]  = (state[v] == IDLE) && empty[v];
         va_x_dest[v*3 +: 3] = front[v][DATA_W-2 -: 3];
         va_y_dest[v*3 +: 3] = front[v][DATA_W-5 -: 3];
      end
   end

   assign sa_hits = sa_grant & sa_req;
   assign served  = sa_hits & (-sa_hits);
   assign pop     = served | discard;

   // A push into a full FIFO survives only when the same VC pops this cycle
   always_comb begin
      push     = '0;
      overflow = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         push[v]     = link.in_valid && (link.in_vc == VC_SIZE'(v)) && (!full[v] || pop[v]);
         overflow[v] = link.in_valid && (link.in_vc == VC_SIZE'(v)) && full[v] && !pop[v];
         occ_next[v] = wr_ptr[v] - rd_ptr[v] + PTR_W'(push[v]) - PTR_W'(pop[v]);
      end
   end

   always_comb begin
      sel_flit = '0;
      sel_vc   = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (served[v]) begin
            sel_flit = front[v];
            sel_vc   = ds_vc[v];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (push[v]) begin
            mem[v][wr_ptr[v][ADDR_W-1:0]] <= {link.in_label, link.in_data};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            state[v]  <= IDLE;
            ds_vc[v]  <= '0;
         end
         link.on_off    <= '1;
         err_overflow   <= '0;
         err_protocol   <= '0;
         link.out_valid <= 1'b0;
         link.out_label <= '0;
         link.out_vc    <= '0;
         link.out_data  <= '0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (push[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
            if (occ_next[v] >= OFF_LVL)     link.on_off[v] <= 1'b0;
            else if (occ_next[v] <= ON_LVL) link.on_off[v] <= 1'b1;
            if (overflow[v]) err_overflow[v] <= 1'b1;
            if (discard[v])  err_protocol[v] <= 1'b1;
            // A grant seen while still IDLE skips the VA state entirely
            case (state[v])
               IDLE: begin
                  if (front_head[v]) begin
                     if (va_grant[v]) begin
                        state[v] <= ACTIVE;
                        ds_vc[v] <= va_vc;
                     end else begin
                        state[v] <= VA;
                     end
                  end
               end
               VA: begin
                  if (va_grant[v]) begin
                     state[v] <= ACTIVE;
                     ds_vc[v] <= va_vc;
                  end
               end
               ACTIVE: begin
                  if (served[v] && front_tail[v]) state[v] <= IDLE;
               end
               default: state[v] <= IDLE;
            endcase
         end
         link.out_valid <= |served;
         if (|served) begin
            link.out_label <= sel_flit[FLIT_W-1 -: 2];
            link.out_vc    <= sel_vc;
            link.out_data  <= sel_flit[DATA_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_vc_input_port.sv
// Bench for vc_input_port: queue-level reference model compared every cycle,
// directed packet/flow-control/error/reset scenarios, then randomized traffic.
module tb_vc_input_port;
   localparam int VC_NUM  = 2;
   localparam int VC_SIZE = 1;
   localparam int DATA_W  = 20;
   localparam int DEPTH   = 8;
   localparam int OFF_LVL = 6;
   localparam int ON_LVL  = 4;
   localparam int S_IDLE = 0, S_VA = 1, S_ACTIVE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [VC_NUM-1:0]   vc_allocatable, va_req, va_grant, ds_on, sa_req, sa_grant;
   logic [VC_NUM-1:0]   err_overflow, err_protocol;
   logic [VC_NUM*3-1:0] va_x_dest, va_y_dest;
   logic [VC_SIZE-1:0]  va_vc;

   always #5 clk = ~clk;

   vc_input_port_if #(.VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE), .DATA_W(DATA_W)) pif ();

   vc_input_port #(
      .VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE), .DATA_W(DATA_W), .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .link(pif),
      .vc_allocatable(vc_allocatable), .va_req(va_req),
      .va_x_dest(va_x_dest), .va_y_dest(va_y_dest),
      .va_grant(va_grant), .va_vc(va_vc), .ds_on(ds_on),
      .sa_req(sa_req), .sa_grant(sa_grant),
      .err_overflow(err_overflow), .err_protocol(err_protocol)
   );

   bit                s_rst, s_valid;
   bit [1:0]          s_label;
   bit [VC_SIZE-1:0]  s_vc, s_va_vc;
   bit [DATA_W-1:0]   s_data;
   bit [VC_NUM-1:0]   s_va_grant, s_ds_on, s_sa_grant;
   bit                mid [VC_NUM];

   logic [21:0]       mq [VC_NUM][$];
   int                mst [VC_NUM];
   int                mds [VC_NUM];
   bit [VC_NUM-1:0]   m_on, m_ovf, m_prot;
   bit                m_out_valid;
   bit [1:0]          m_out_label;
   int                m_out_vc;
   bit [DATA_W-1:0]   m_out_data;
   bit                model_ok;
   bit [VC_NUM-1:0]   e_va_req, e_sa_req, e_alloc;

   int total = 0;
   int bad   = 0;

   function automatic bit is_head(input logic [1:0] l);
      return (l == 2'd0) || (l == 2'd3);
   endfunction

   function automatic bit is_tail(input logic [1:0] l);
      return (l == 2'd2) || (l == 2'd3);
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s[%0d] t=%0t got=%0h want=%0h", name, idx, $time, act, exp);
      end
   endtask

   task automatic clearStim();
      s_rst = 0; s_valid = 0; s_label = 0; s_vc = 0; s_data = 0;
      s_va_grant = 0; s_va_vc = 0; s_ds_on = '1; s_sa_grant = 0;
   endtask

   task automatic modelComb();
      for (int v = 0; v < VC_NUM; v++) begin
         bit nonempty = (mq[v].size() > 0);
         logic [21:0] f = nonempty ? mq[v][0] : 22'd0;
         e_alloc[v]  = (mst[v] == S_IDLE) && !nonempty;
         e_va_req[v] = (mst[v] == S_VA) || ((mst[v] == S_IDLE) && nonempty && is_head(f[21:20]));
         e_sa_req[v] = (mst[v] == S_ACTIVE) && nonempty && s_ds_on[mds[v]];
      end
   endtask

   task automatic checkOutput();
      if (!model_ok) return;
      for (int v = 0; v < VC_NUM; v++) begin
         cmp("va_req", v, 32'(va_req[v]), 32'(e_va_req[v]));
         cmp("sa_req", v, 32'(sa_req[v]), 32'(e_sa_req[v]));
         cmp("vc_allocatable", v, 32'(vc_allocatable[v]), 32'(e_alloc[v]));
         cmp("on_off", v, 32'(pif.on_off[v]), 32'(m_on[v]));
         cmp("err_overflow", v, 32'(err_overflow[v]), 32'(m_ovf[v]));
         cmp("err_protocol", v, 32'(err_protocol[v]), 32'(m_prot[v]));
         if (e_va_req[v]) begin
            cmp("va_x_dest", v, 32'(va_x_dest[v*3 +: 3]), 32'(mq[v][0][18:16]));
            cmp("va_y_dest", v, 32'(va_y_dest[v*3 +: 3]), 32'(mq[v][0][15:13]));
         end
      end
      cmp("out_valid", 0, 32'(pif.out_valid), 32'(m_out_valid));
      cmp("out_label", 0, 32'(pif.out_label), 32'(m_out_label));
      cmp("out_vc", 0, 32'(pif.out_vc), 32'(m_out_vc));
      cmp("out_data", 0, 32'(pif.out_data), 32'(m_out_data));
   endtask

   task automatic modelStep();
      int served = -1;
      if (s_rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete(); mst[v] = S_IDLE; mds[v] = 0;
         end
         m_on = '1; m_ovf = '0; m_prot = '0;
         m_out_valid = 0; m_out_label = 0; m_out_vc = 0; m_out_data = 0;
         model_ok = 1;
         return;
      end
      if (!model_ok) return;
      for (int v = 0; v < VC_NUM; v++)
         if (served < 0 && e_sa_req[v] && s_sa_grant[v]) served = v;
      m_out_valid = (served >= 0);
      for (int v = 0; v < VC_NUM; v++) begin
         logic [21:0] f;
         case (mst[v])
            S_IDLE: if (mq[v].size() > 0) begin
               if (is_head(mq[v][0][21:20])) begin
                  if (s_va_grant[v]) begin mst[v] = S_ACTIVE; mds[v] = int'(s_va_vc); end
                  else mst[v] = S_VA;
               end else begin
                  f = mq[v].pop_front();
                  m_prot[v] = 1;
               end
            end
            S_VA: if (s_va_grant[v]) begin mst[v] = S_ACTIVE; mds[v] = int'(s_va_vc); end
            default: if (v == served) begin
               f = mq[v].pop_front();
               m_out_label = f[21:20];
               m_out_data  = f[19:0];
               m_out_vc    = mds[v];
               if (is_tail(f[21:20])) mst[v] = S_IDLE;
            end
         endcase
      end
      if (s_valid) begin
         if (mq[s_vc].size() < DEPTH) mq[s_vc].push_back({s_label, s_data});
         else m_ovf[s_vc] = 1;
      end
      for (int v = 0; v < VC_NUM; v++) begin
         if (mq[v].size() >= OFF_LVL)     m_on[v] = 0;
         else if (mq[v].size() <= ON_LVL) m_on[v] = 1;
      end
   endtask

   // One clock: drive at the falling edge, sample 1ns later, advance the model
   task automatic applyStimulus();
      @(negedge clk);
      rst = s_rst;
      pif.in_valid = s_valid; pif.in_label = s_label; pif.in_vc = s_vc; pif.in_data = s_data;
      va_grant = s_va_grant; va_vc = s_va_vc; ds_on = s_ds_on; sa_grant = s_sa_grant;
      #1;
      modelComb();
      checkOutput();
      modelStep();
   endtask

   task automatic doReset();
      clearStim();
      s_rst = 1;
      applyStimulus();
      s_rst = 0;
      foreach (mid[v]) mid[v] = 0;
   endtask

   task automatic randomStim(input int push_pct, input int pop_pct);
      int v;
      s_rst   = ($urandom_range(0, 599) == 0);
      v       = $urandom_range(0, VC_NUM-1);
      s_vc    = VC_SIZE'(v);
      s_valid = ($urandom_range(0, 99) < push_pct);
      if ($urandom_range(0, 19) == 0) begin
         s_label = 2'($urandom);
      end else if (!mid[v]) begin
         s_label = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
         if (s_valid) mid[v] = (s_label == 2'd0);
      end else begin
         s_label = ($urandom_range(0, 2) == 0) ? 2'd2 : 2'd1;
         if (s_valid && s_label == 2'd2) mid[v] = 0;
      end
      s_data     = DATA_W'($urandom);
      s_va_grant = VC_NUM'($urandom);
      s_va_vc    = VC_SIZE'($urandom);
      for (int i = 0; i < VC_NUM; i++) s_ds_on[i] = ($urandom_range(0, 3) != 0);
      s_sa_grant = ($urandom_range(0, 99) < pop_pct) ? VC_NUM'($urandom) : '0;
      if (s_rst) foreach (mid[i]) mid[i] = 0;
   endtask

   initial begin
      bit [1:0]        lab [4];
      bit [DATA_W-1:0] dat [4];
      bit [DATA_W-1:0] ht_data;
      lab = '{2'd0, 2'd1, 2'd1, 2'd2};

      clearStim();
      s_rst = 1;
      applyStimulus();
      doReset();

      // reset state and single HEADTAIL fast path on VC1
      clearStim();
      applyStimulus();
      cmp("rst_on_off", 0, 32'(pif.on_off), 32'h3);
      cmp("rst_alloc", 0, 32'(vc_allocatable), 32'h3);
      cmp("rst_out_valid", 0, 32'(pif.out_valid), 32'h0);
      cmp("rst_out_data", 0, 32'(pif.out_data), 32'h0);
      ht_data = {1'b0, 3'd3, 3'd2, 13'h0a5};
      clearStim(); s_valid = 1; s_vc = 1; s_label = 2'd3; s_data = ht_data;
      applyStimulus();
      clearStim(); s_va_grant = 2'b10; s_va_vc = 0;
      applyStimulus();
      cmp("t1_va_req", 1, 32'(va_req), 32'h2);
      cmp("t1_x_dest", 1, 32'(va_x_dest[5:3]), 32'd3);
      cmp("t1_y_dest", 1, 32'(va_y_dest[5:3]), 32'd2);
      clearStim(); s_sa_grant = 2'b10;
      applyStimulus();
      cmp("t2_sa_req", 1, 32'(sa_req), 32'h2);
      clearStim();
      applyStimulus();
      cmp("t3_out_valid", 0, 32'(pif.out_valid), 32'h1);
      cmp("t3_out_vc", 0, 32'(pif.out_vc), 32'h0);
      cmp("t3_out_label", 0, 32'(pif.out_label), 32'h3);
      cmp("t3_out_data", 0, 32'(pif.out_data), 32'(ht_data));
      cmp("t3_alloc", 1, 32'(vc_allocatable[1]), 32'h1);
      applyStimulus();
      cmp("t4_out_valid", 0, 32'(pif.out_valid), 32'h0);
      cmp("t4_label_hold", 0, 32'(pif.out_label), 32'h3);

      // 4-flit packet on VC0 held back by downstream off
      doReset();
      for (int i = 0; i < 4; i++) begin
         clearStim();
         dat[i] = DATA_W'($urandom);
         s_valid = 1; s_vc = 0; s_label = lab[i]; s_data = dat[i];
         s_va_grant = 2'b01; s_va_vc = 1; s_ds_on = 2'b01; s_sa_grant = 2'b01;
         applyStimulus();
         if (i >= 2) cmp("ds_off_sa_req", i, 32'(sa_req[0]), 32'h0);
      end
      clearStim(); s_ds_on = 2'b10; s_sa_grant = 2'b01;
      applyStimulus();
      cmp("ds_on_sa_req", 0, 32'(sa_req[0]), 32'h1);
      for (int j = 0; j < 4; j++) begin
         applyStimulus();
         cmp("pkt_out_valid", j, 32'(pif.out_valid), 32'h1);
         cmp("pkt_out_label", j, 32'(pif.out_label), 32'(lab[j]));
         cmp("pkt_out_vc", j, 32'(pif.out_vc), 32'h1);
         cmp("pkt_out_data", j, 32'(pif.out_data), 32'(dat[j]));
      end
      cmp("pkt_done_alloc", 0, 32'(vc_allocatable[0]), 32'h1);

      // fill VC0, push-while-pop on full, overflow, drain hysteresis
      doReset();
      for (int i = 0; i < 8; i++) begin
         clearStim(); s_valid = 1; s_vc = 0; s_label = (i == 0) ? 2'd0 : 2'd1;
         s_data = DATA_W'($urandom);
         applyStimulus();
         if (i == 5) cmp("fill_on_occ5", 0, 32'(pif.on_off[0]), 32'h1);
         if (i == 6) cmp("fill_off_occ6", 0, 32'(pif.on_off[0]), 32'h0);
      end
      clearStim(); s_va_grant = 2'b01; s_va_vc = 0;
      applyStimulus();
      clearStim(); s_valid = 1; s_vc = 0; s_label = 2'd1; s_sa_grant = 2'b01;
      applyStimulus();
      cmp("full_sa_req", 0, 32'(sa_req[0]), 32'h1);
      clearStim();
      applyStimulus();
      cmp("full_pushpop_ovf", 0, 32'(err_overflow[0]), 32'h0);
      cmp("full_pushpop_out", 0, 32'(pif.out_valid), 32'h1);
      cmp("full_pushpop_lbl", 0, 32'(pif.out_label), 32'h0);
      clearStim(); s_valid = 1; s_vc = 0; s_label = 2'd1;
      applyStimulus();
      clearStim();
      applyStimulus();
      cmp("ovf_sticky", 0, 32'(err_overflow[0]), 32'h1);
      for (int i = 0; i < 4; i++) begin
         clearStim(); s_sa_grant = 2'b01;
         applyStimulus();
      end
      cmp("drain_occ5_off", 0, 32'(pif.on_off[0]), 32'h0);
      clearStim();
      applyStimulus();
      cmp("drain_occ4_on", 0, 32'(pif.on_off[0]), 32'h1);

      // stray BODY on idle VC1
      doReset();
      clearStim(); s_valid = 1; s_vc = 1; s_label = 2'd1;
      applyStimulus();
      clearStim();
      applyStimulus();
      cmp("body_no_va_req", 1, 32'(va_req[1]), 32'h0);
      applyStimulus();
      cmp("body_err_protocol", 1, 32'(err_protocol[1]), 32'h1);
      cmp("body_alloc", 1, 32'(vc_allocatable[1]), 32'h1);

      // reset while VC0 is ACTIVE with 3 flits
      doReset();
      for (int i = 0; i < 3; i++) begin
         clearStim(); s_valid = 1; s_vc = 0; s_label = (i == 0) ? 2'd0 : 2'd1;
         s_ds_on = 2'b00; s_va_grant = (i == 1) ? 2'b01 : 2'b00;
         applyStimulus();
      end
      clearStim(); s_ds_on = 2'b00;
      applyStimulus();
      cmp("mid_sa_req", 0, 32'(sa_req[0]), 32'h0);
      cmp("mid_alloc", 0, 32'(vc_allocatable[0]), 32'h0);
      clearStim(); s_rst = 1; s_ds_on = 2'b00;
      applyStimulus();
      clearStim();
      applyStimulus();
      cmp("mid_rst_on_off", 0, 32'(pif.on_off), 32'h3);
      cmp("mid_rst_alloc", 0, 32'(vc_allocatable), 32'h3);
      cmp("mid_rst_out_valid", 0, 32'(pif.out_valid), 32'h0);
      cmp("mid_rst_va_req", 0, 32'(va_req), 32'h0);

      // randomized traffic: balanced, congested (overflow), draining
      doReset();
      for (int c = 0; c < 1500; c++) begin randomStim(60, 70); applyStimulus(); end
      for (int c = 0; c < 1000; c++) begin randomStim(90, 10); applyStimulus(); end
      for (int c = 0; c < 1000; c++) begin randomStim(30, 90); applyStimulus(); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
